// File: rtl/flt2fix_pkg.sv
// Shared types and constants for the binary16 to fixed-point converter.
package flt2fix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } rnd_mode_e;

  localparam int FLT_W     = 16;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;
  localparam int SIG_W     = MANT_W + 1;
  localparam int EXP_BIAS  = 15;
  localparam int SHIFT_CAP = 13;
  localparam int CNT_W     = 4;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

endpackage

// File: rtl/flt2fix_round.sv
// Rounds an unsigned magnitude using guard/sticky, applies the sign and
// saturates when the rounded value no longer fits the signed result.
module flt2fix_round
  import flt2fix_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int MAG_W = 16
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  rnd_mode_e        mode_i,
  input  logic             sign_i,
  output logic [OUT_W-1:0] result_o,
  output logic             ovf_o
);

  localparam int SUM_W = MAG_W + 1;
  localparam logic [SUM_W-1:0] POS_LIM = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [SUM_W-1:0] NEG_LIM = SUM_W'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] FIX_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FIX_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic             inc_w;
  logic [SUM_W-1:0] sum_w;
  logic [OUT_W-1:0] mag_t_w;

  always_comb begin
    inc_w   = (mode_i == RND_RNE) && guard_i && (sticky_i || mag_i[0]);
    sum_w   = {1'b0, mag_i} + SUM_W'(inc_w);
    mag_t_w = sum_w[OUT_W-1:0];
    // The most negative value has one more unit of magnitude than the most positive.
    ovf_o   = sign_i ? (sum_w > NEG_LIM) : (sum_w > POS_LIM);
    if (ovf_o) begin
      result_o = sign_i ? FIX_MIN : FIX_MAX;
    end else begin
      result_o = sign_i ? (~mag_t_w + 1'b1) : mag_t_w;
    end
  end

endmodule

// File: rtl/flt2fix_conv.sv
// Multi-cycle IEEE binary16 to signed fixed-point converter with a
// one-bit-per-cycle shifter and selectable truncate / round-to-nearest-even.
module flt2fix_conv
  import flt2fix_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      flt_in,
  input  logic             rnd_mode,
  output logic [OUT_W-1:0] fix_out,
  output logic             ack,
  output logic             busy,
  output logic             sat
);

  localparam int MAG_W   = (OUT_W > SIG_W) ? OUT_W : SIG_W;
  localparam int SAT_EXP = OUT_W - 1 - FRAC_W + EXP_BIAS;
  localparam logic [OUT_W-1:0] FIX_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FIX_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_e           state_q;
  logic [FLT_W-1:0] flt_q;
  rnd_mode_e        mode_q;
  logic [MAG_W-1:0] mag_q;
  logic             guard_q;
  logic             sticky_q;
  logic             left_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] fix_q;
  logic             sat_q;
  logic             ack_q;
  logic             busy_q;

  logic [EXP_W-1:0] exp_w;
  logic [SIG_W-1:0] sig_w;
  logic             sign_w;
  logic             is_zero_w;
  logic             is_sat_w;
  logic             shift_left_w;
  logic [CNT_W-1:0] shift_amt_w;
  int               d_int;
  int               abs_int;
  logic [OUT_W-1:0] round_res_w;
  logic             round_ovf_w;

  assign exp_w  = flt_q[14:10];
  assign sign_w = flt_q[15];
  assign sig_w  = {|exp_w, flt_q[9:0]};

  // d places the significand LSB (weight 2^(exp-25)) at the result LSB (weight 2^-FRAC_W).
  always_comb begin
    d_int   = int'(exp_w) - (EXP_BIAS + MANT_W) + FRAC_W;
    abs_int = (d_int < 0) ? -d_int : d_int;
    if (abs_int > SHIFT_CAP) begin
      abs_int = SHIFT_CAP;
    end
    shift_amt_w  = CNT_W'(abs_int);
    shift_left_w = (d_int > 0);
    is_zero_w    = (exp_w == '0);
    is_sat_w     = (exp_w == EXP_ALL_ONES) || (int'(exp_w) >= SAT_EXP);
  end

  flt2fix_round #(
    .OUT_W (OUT_W),
    .MAG_W (MAG_W)
  ) u_round (
    .mag_i    (mag_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .mode_i   (mode_q),
    .sign_i   (sign_w),
    .result_o (round_res_w),
    .ovf_o    (round_ovf_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      flt_q    <= '0;
      mode_q   <= RND_TRUNC;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
      fix_q    <= '0;
      sat_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The ack cycle sits in IDLE with busy still high, so start is refused there.
          if (start && !busy_q) begin
            flt_q   <= flt_in;
            mode_q  <= rnd_mode_e'(rnd_mode);
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end else if (ack_q) begin
            busy_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          mag_q    <= MAG_W'(sig_w);
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
          left_q   <= shift_left_w;
          cnt_q    <= shift_amt_w;
          if (is_zero_w) begin
            fix_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (is_sat_w) begin
            fix_q   <= sign_w ? FIX_MIN : FIX_MAX;
            sat_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (shift_amt_w == '0) begin
            state_q <= ST_ROUND;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            mag_q    <= mag_q >> 1;
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          fix_q   <= round_res_w;
          sat_q   <= round_ovf_w;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fix_out = fix_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign sat     = sat_q;

endmodule

// File: doc/flt2fix_conv.md
FLT2FIX_CONV -- requirements
Module: flt2fix_conv

Interface
REQ-001 Parameter OUT_W, default 16: fixed-point result width, two's complement; legal range 8..24.
REQ-002 Parameter FRAC_W, default 8: fraction bits of the result; legal range 0..OUT_W-2; default gives Q8.8.
REQ-003 Ports: clk  in  1  sole clock; all state on rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 Ports: start  in  1  request pulse; sampled only in IDLE.
REQ-006 Ports: flt_in  in  16  IEEE binary16 operand (sign, exp[14:10] bias 15, mant[9:0]).
REQ-007 Ports: rnd_mode  in  1  0 = truncate toward zero, 1 = round-to-nearest-even.
REQ-008 Ports: fix_out  out  OUT_W  result, held stable from ack until next accepted start.
REQ-009 Ports: ack  out  1  one-cycle completion pulse.
REQ-010 Ports: busy  out  1  high from accepted start through the ack cycle.
REQ-011 Ports: sat  out  1  result was saturated; valid with fix_out.

Function
REQ-012 Shall capture flt_in and rnd_mode at the edge where state=IDLE and start=1; later input changes do not affect the operation.
REQ-013 Shall ignore start whenever busy=1, with no queuing.
REQ-014 States: IDLE, LOAD, SHIFT, ROUND, DONE; DONE returns to IDLE on the next edge.
REQ-015 LOAD classifies the operand and forms the 11-bit significand (hidden bit = |exp) and shift amount d = exp-25+FRAC_W.
REQ-016 Exp=0 (zero/subnormal): fix_out=0, sat=0; LOAD goes to DONE.
REQ-017 Exp=31, or unbiased exp >= OUT_W-1-FRAC_W: saturate (+ max 2^(OUT_W-1)-1, - min -2^(OUT_W-1)), sat=1; LOAD goes to DONE.
REQ-018 Otherwise SHIFT moves the magnitude one bit per cycle for S=min(|d|,13) cycles: left if d>0, right if d<0.
REQ-019 Right shifts shall keep guard and sticky bits; S=0 skips SHIFT.
REQ-020 ROUND applies rnd_mode to the magnitude, then negates if the sign is set (truncation is therefore toward zero).
REQ-021 A rounding carry that exceeds range saturates and sets sat=1.
REQ-022 Latency: start accepted at edge 0; ack high after edge 3+S in the normal path and after edge 2 in the special paths.
REQ-023 ack shall be high exactly one cycle; busy falls with it.

Reset
REQ-024 reset=0 shall asynchronously force state=IDLE and fix_out=0, ack=0, busy=0, sat=0, clearing all internal registers.
REQ-025 Reset mid-operation shall abandon the operation with no ack.
REQ-026 The first start is accepted on the first edge after reset deasserts.

Structure
REQ-027 Package flt2fix_pkg holds the state enum, rounding-mode enum, binary16 field widths, bias constant 15, and shift cap 13.
REQ-028 One sub-module flt2fix_round (combinational: magnitude, guard, sticky, mode, sign -> result, overflow) shall be used in ROUND.

Verification
REQ-029 The bench shall cover these directed scenarios (defaults, rnd_mode=0 unless stated):
- flt_in=0x3C00 (1.0) -> fix_out=0x0100, sat=0, ack after edge 5.
- 0x3D00 -> 0x0140; 0xBC00 -> 0xFF00; 0x5780 -> 0x7800 with ack after edge 7.
- 0x3C06: rnd_mode=0 -> 0x0101; rnd_mode=1 -> 0x0102. 0x3C02 with rnd_mode=1 -> 0x0100 (tie to even).
- 0x5B00 -> 0x7FFF with sat=1 and ack after edge 2; 0xDB00 -> 0x8000 with sat=1; 0x7C00 -> 0x7FFF; 0x0000 and 0x8000 -> 0x0000.
- start pulsed again while busy -> ignored, exactly one ack; reset=0 during SHIFT -> all outputs 0 at once and no ack.
- OUT_W=12, FRAC_W=4 instance: 0x3C00 -> 0x010; 0x5000 (32.0) -> 0x200; 0x5800 (128.0) -> 0x7FF with sat=1.
